fetch_sequencer: RTL and testbench

Program-counter sequencer for the fetch stage. Drives the byte address into the combinational instruction memory and captures the returned 32-bit big-endian word into an output register. Presents the captured word to decode over a valid/ready handshake. Handles branch redirects and flushes, and stops on a halt word.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC sequencer with capture register, branch flush and halt
// Optional feature macro: FETCH_BOUND_CHECK_EN (fault on out-of-range fetch or branch target)
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Byte addresses are kept inside the memory window by masking.
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  state_t      state;
  logic [31:0] pc;
  logic        fault_q;

  logic [31:0] target_aligned;
  logic [31:0] pc_inc;
  logic        out_free;
  logic        target_oob;
  logic        seq_oob;

  assign mem_address    = pc;
  assign target_aligned = branch_target & ~32'd3 & ADDR_MASK;
  assign pc_inc         = (pc + 32'd4) & ADDR_MASK;
  assign out_free       = !inst_valid || inst_ready;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);

  // Out-of-window branch targets and running off the end both trap.
  assign target_oob = (branch_target >= MEM_LIMIT);
  assign seq_oob    = (pc == LAST_PC);
`else
  // Without bound checking the window simply wraps; nothing can trap.
  assign target_oob = 1'b0;
  assign seq_oob    = 1'b0;
`endif

  assign fault = fault_q;

  // Sequencer FSM: owns pc, the output register, halted and the sticky fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_out   <= 32'd0;
      inst_pc    <= 32'd0;
      halted     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (branch_valid && target_oob) begin
            state   <= ST_HALT;
            halted  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            if (branch_valid) begin
              pc <= target_aligned;
            end
            if (start) begin
              state <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (branch_valid) begin
            // Redirect wins over capture and stall; the held word is dropped.
            if (target_oob) begin
              state   <= ST_HALT;
              halted  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              pc         <= target_aligned;
              inst_valid <= 1'b0;
            end
          end else if (out_free) begin
            if (mem_inst == HALT_WORD) begin
              // Halt word is never presented; a pending word still drains.
              state  <= ST_HALT;
              halted <= 1'b1;
              if (inst_ready) begin
                inst_valid <= 1'b0;
              end
            end else begin
              inst_out   <= mem_inst;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              if (seq_oob) begin
                state   <= ST_HALT;
                halted  <= 1'b1;
                fault_q <= 1'b1;
              end else begin
                pc <= pc_inc;
              end
            end
          end
        end

        ST_HALT: begin
          // Frozen except for letting decode take the last captured word.
          if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] mem_address;
  logic [31:0] mem_inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fault;

  logic [31:0] mem [64];
  exp_t        sb[$];
  int          n_total;
  int          n_pass;

  fetch_sequencer #(
    .MEM_BYTES(256),
    .RESET_PC (32'h0),
    .HALT_WORD(HALT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .mem_address  (mem_address),
    .mem_inst     (mem_inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .halted       (halted),
    .fault        (fault)
  );

  assign mem_inst = mem[mem_address[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.pc   = addr;
    e.word = mem[addr[7:2]];
    sb.push_back(e);
  endtask

  function automatic logic [31:0] pattern(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 64; i++) mem[i] = pattern(i);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
  endtask

  // Accepted words are compared against the scoreboard at the negedge
  // before the accepting edge; a same-cycle redirect drops the word.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready && !(branch_valid && !halted)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", inst_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", inst_pc, e.pc);
        check("sb_word", inst_out, e.word);
      end
    end
  end

  initial begin
    n_total       = 0;
    n_pass        = 0;
    reset         = 1'b1;
    start         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'd0;
    inst_ready    = 1'b1;
    load_mem();
    tick();
    tick();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_out", inst_out, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();

    // Sequential fetch, stall, branch
    push(32'h0);
    push(32'h4);
    push(32'h8);
    push(32'h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_not_yet", 32'(inst_valid), 32'd0);
    tick();
    check("lat_valid", 32'(inst_valid), 32'd1);
    check("first_pc", inst_pc, 32'h0);
    tick();
    check("second_pc", inst_pc, 32'h4);
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out", inst_out, 32'h2222_2222);
      check("stall_pc", inst_pc, 32'h4);
      check("stall_addr", mem_address, 32'h8);
    end
    inst_ready = 1'b1;
    tick();
    check("after_stall_out", inst_out, 32'h3333_3333);
    tick();
    check("pre_branch_pc", inst_pc, 32'hC);
    branch_valid  = 1'b1;
    branch_target = 32'h43;
    tick();
    branch_valid = 1'b0;
    check("branch_flush", 32'(inst_valid), 32'd0);
    check("branch_addr", mem_address, 32'h40);
    tick();
    check("branch_valid_again", 32'(inst_valid), 32'd1);
    check("branch_pc", inst_pc, 32'h40);
    tick();
    inst_ready = 1'b0;
    check("post_branch_pc", inst_pc, 32'h44);
    check("sb_drain_a", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a stall
    tick();
    reset = 1'b1;
    #1;
    check("async_valid", 32'(inst_valid), 32'd0);
    check("async_out", inst_out, 32'd0);
    check("async_pc", inst_pc, 32'd0);
    check("async_addr", mem_address, 32'd0);
    tick();
    reset = 1'b0;
    inst_ready = 1'b1;

    // Halt word at 0x0C
    mem[3] = HALT_W;
    push(32'h0);
    push(32'h4);
    push(32'h8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(inst_valid), 32'd0);
    check("halt_addr", mem_address, 32'hC);
    start         = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 32'h80;
    tick();
    tick();
    start        = 1'b0;
    branch_valid = 1'b0;
    check("halt_hold_addr", mem_address, 32'hC);
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_hold_valid", 32'(inst_valid), 32'd0);
    check("sb_drain_b", 32'(sb.size()), 32'd0);

    // Idle branch, then run off the end of memory
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_mem();
    branch_valid  = 1'b1;
    branch_target = 32'hF6;
    tick();
    branch_valid = 1'b0;
    check("idle_branch_addr", mem_address, 32'hF4);
    check("idle_branch_valid", 32'(inst_valid), 32'd0);
    push(32'hF4);
    push(32'hF8);
    push(32'hFC);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("last_pc", inst_pc, 32'hFC);
`ifdef FETCH_BOUND_CHECK_EN
    check("bound_fault", 32'(fault), 32'd1);
    check("bound_halted", 32'(halted), 32'd1);
    check("bound_valid", 32'(inst_valid), 32'd1);
    tick();
    check("bound_drained", 32'(inst_valid), 32'd0);
    check("bound_addr", mem_address, 32'hFC);
`else
    tick();
    inst_ready = 1'b0;
    check("wrap_pc", inst_pc, 32'h0);
    check("wrap_word", inst_out, mem[0]);
    check("wrap_fault", 32'(fault), 32'd0);
    check("wrap_halted", 32'(halted), 32'd0);
`endif
    tick();
    check("sb_drain_c", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
